// File: rtl/id_issue_ctrl.sv
// Issue controller and load scoreboard between decode and execute.
// Stalls on load-use/WAW hazards, a full load budget or EX back-pressure, and sequences the redirect flush window.
module id_issue_ctrl #(
    parameter int MAX_LOADS       = 4,
    parameter int REDIRECT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_id_valid,
    input  logic        i_rs1_r_ena,
    input  logic        i_rs2_r_ena,
    input  logic [4:0]  i_rs1_r_addr,
    input  logic [4:0]  i_rs2_r_addr,
    input  logic        i_rd_w_ena,
    input  logic [4:0]  i_rd_w_addr,
    input  logic        i_mem_to_reg,
    input  logic        i_ex_ready,
    input  logic        i_ex_redirect,
    input  logic        i_wb_load_valid,
    input  logic [4:0]  i_wb_load_rd,
    output logic        o_id_issue,
    output logic        o_id_stall,
    output logic        o_id_flush,
    output logic [31:0] o_busy_vec,
    output logic [3:0]  o_load_cnt,
    output logic [31:0] o_stall_cnt
);

    localparam logic [3:0] LP_MAX_LOADS = 4'(MAX_LOADS);
    localparam logic [2:0] LP_RELOAD    = 3'(REDIRECT_CYCLES - 1);

    typedef enum logic {
        S_RUN      = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_redir_cnt;
    logic [2:0]  w_redir_cnt_nxt;
    logic [31:0] r_busy_vec;
    logic [31:0] w_busy_nxt;
    logic [3:0]  r_load_cnt;
    logic [31:0] r_stall_cnt;

    logic w_raw1;
    logic w_raw2;
    logic w_waw;
    logic w_full;
    logic w_set;
    logic w_inc;
    logic w_dec;

    // Hazards look only at the registered scoreboard: a same-cycle writeback does not bypass.
    assign w_raw1 = i_rs1_r_ena & (i_rs1_r_addr != 5'd0) & r_busy_vec[i_rs1_r_addr];
    assign w_raw2 = i_rs2_r_ena & (i_rs2_r_addr != 5'd0) & r_busy_vec[i_rs2_r_addr];
    assign w_waw  = i_rd_w_ena  & (i_rd_w_addr  != 5'd0) & r_busy_vec[i_rd_w_addr];
    assign w_full = i_mem_to_reg & (r_load_cnt == LP_MAX_LOADS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_redir_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_redir_cnt <= w_redir_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_redir_cnt_nxt = r_redir_cnt;
        o_id_issue      = 1'b0;
        o_id_stall      = 1'b0;
        o_id_flush      = i_ex_redirect;
        case (r_state)
            S_RUN: begin
                if (i_ex_redirect) begin
                    w_state_nxt     = S_REDIRECT;
                    w_redir_cnt_nxt = LP_RELOAD;
                end else begin
                    o_id_issue = i_id_valid & i_ex_ready & ~w_raw1 & ~w_raw2 & ~w_waw & ~w_full;
                    o_id_stall = i_id_valid & ~o_id_issue;
                end
            end
            S_REDIRECT: begin
                o_id_flush = 1'b1;
                if (i_ex_redirect) begin
                    w_redir_cnt_nxt = LP_RELOAD;
                end else if (r_redir_cnt == 3'd0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_redir_cnt_nxt = r_redir_cnt - 3'd1;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Loads to x0 still occupy a budget slot but never mark a register busy.
    assign w_set = o_id_issue & i_mem_to_reg & i_rd_w_ena & (i_rd_w_addr != 5'd0);
    assign w_inc = o_id_issue & i_mem_to_reg;
    assign w_dec = i_wb_load_valid & (r_load_cnt != 4'd0);

    always_comb begin
        w_busy_nxt = r_busy_vec;
        if (i_wb_load_valid) begin
            w_busy_nxt[i_wb_load_rd] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[i_rd_w_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_vec  <= 32'd0;
            r_load_cnt  <= 4'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_busy_vec <= w_busy_nxt;
            if (w_inc && !w_dec) begin
                r_load_cnt <= r_load_cnt + 4'd1;
            end else if (w_dec && !w_inc) begin
                r_load_cnt <= r_load_cnt - 4'd1;
            end
            if (o_id_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_busy_vec  = r_busy_vec;
    assign o_load_cnt  = r_load_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed scoreboard bench for id_issue_ctrl: expectations are queued per cycle and checked at the falling edge.
module tb_id_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        rs1_r_ena;
    logic        rs2_r_ena;
    logic [4:0]  rs1_r_addr;
    logic [4:0]  rs2_r_addr;
    logic        rd_w_ena;
    logic [4:0]  rd_w_addr;
    logic        mem_to_reg;
    logic        ex_ready;
    logic        ex_redirect;
    logic        wb_load_valid;
    logic [4:0]  wb_load_rd;
    logic        id_issue;
    logic        id_stall;
    logic        id_flush;
    logic [31:0] busy_vec;
    logic [3:0]  load_cnt;
    logic [31:0] stall_cnt;

    id_issue_ctrl #(.MAX_LOADS(4), .REDIRECT_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_id_valid     (id_valid),
        .i_rs1_r_ena    (rs1_r_ena),
        .i_rs2_r_ena    (rs2_r_ena),
        .i_rs1_r_addr   (rs1_r_addr),
        .i_rs2_r_addr   (rs2_r_addr),
        .i_rd_w_ena     (rd_w_ena),
        .i_rd_w_addr    (rd_w_addr),
        .i_mem_to_reg   (mem_to_reg),
        .i_ex_ready     (ex_ready),
        .i_ex_redirect  (ex_redirect),
        .i_wb_load_valid(wb_load_valid),
        .i_wb_load_rd   (wb_load_rd),
        .o_id_issue     (id_issue),
        .o_id_stall     (id_stall),
        .o_id_flush     (id_flush),
        .o_busy_vec     (busy_vec),
        .o_load_cnt     (load_cnt),
        .o_stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int SG_ISSUE = 0;
    localparam int SG_STALL = 1;
    localparam int SG_FLUSH = 2;
    localparam int SG_BUSY  = 3;
    localparam int SG_CNT   = 4;
    localparam int SG_SCNT  = 5;

    typedef struct {
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_no   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", tag, cyc_no, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            SG_ISSUE: return {31'd0, id_issue};
            SG_STALL: return {31'd0, id_stall};
            SG_FLUSH: return {31'd0, id_flush};
            SG_BUSY:  return busy_vec;
            SG_CNT:   return {28'd0, load_cnt};
            default:  return stall_cnt;
        endcase
    endfunction

    task automatic push(input int sig, input logic [31:0] val, input string tag);
        exp_t e;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic expc(input logic iss, input logic stl, input logic fl);
        push(SG_ISSUE, {31'd0, iss}, "id_issue");
        push(SG_STALL, {31'd0, stl}, "id_stall");
        push(SG_FLUSH, {31'd0, fl},  "id_flush");
    endtask

    task automatic exps(input logic [31:0] busy, input logic [3:0] cnt, input logic [31:0] scnt);
        push(SG_BUSY, busy,          "busy_vec");
        push(SG_CNT,  {28'd0, cnt},  "load_cnt");
        push(SG_SCNT, scnt,          "stall_cnt");
    endtask

    task automatic compare_all();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    // Check this cycle at the falling edge, then advance past the rising edge and clear one-shot inputs.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        cyc_no++;
        wb_load_valid = 1'b0;
        ex_redirect   = 1'b0;
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        rs1_r_ena  = 1'b0;
        rs2_r_ena  = 1'b0;
        rs1_r_addr = 5'd0;
        rs2_r_addr = 5'd0;
        rd_w_ena   = 1'b0;
        rd_w_addr  = 5'd0;
        mem_to_reg = 1'b0;
    endtask

    task automatic op_ld(input logic [4:0] rd, input logic [4:0] rs1);
        id_valid   = 1'b1;
        rs1_r_ena  = 1'b1;
        rs1_r_addr = rs1;
        rs2_r_ena  = 1'b0;
        rs2_r_addr = 5'd0;
        rd_w_ena   = 1'b1;
        rd_w_addr  = rd;
        mem_to_reg = 1'b1;
    endtask

    task automatic op_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid   = 1'b1;
        rs1_r_ena  = 1'b1;
        rs1_r_addr = rs1;
        rs2_r_ena  = 1'b1;
        rs2_r_addr = rs2;
        rd_w_ena   = 1'b1;
        rd_w_addr  = rd;
        mem_to_reg = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_load_valid = 1'b1;
        wb_load_rd    = rd;
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(wb_load_valid && load_cnt == 4'd0))
                else $error("writeback with no outstanding load");
            assert (!(id_issue && mem_to_reg && rd_w_ena && rd_w_addr != 5'd0 &&
                      wb_load_valid && wb_load_rd == rd_w_addr))
                else $error("same-register set and clear in one cycle");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        ex_ready      = 1'b1;
        ex_redirect   = 1'b0;
        wb_load_valid = 1'b0;
        wb_load_rd    = 5'd0;
        idle();

        // reset state
        #2;
        expc(0, 0, 0);
        exps(32'd0, 4'd0, 32'd0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // load-use
        op_ld(5'd5, 5'd2);  expc(1, 0, 0); tick();
        op_alu(5'd6, 5'd5, 5'd1);
        expc(0, 1, 0); exps(32'h20, 4'd1, 32'd0); tick();
        expc(0, 1, 0); exps(32'h20, 4'd1, 32'd1); tick();
        wb(5'd5);
        expc(0, 1, 0); exps(32'h20, 4'd1, 32'd2); tick();
        expc(1, 0, 0); exps(32'h0,  4'd0, 32'd3); tick();

        // load budget
        for (int i = 1; i <= 4; i++) begin
            op_ld(5'(i), 5'd0); expc(1, 0, 0); tick();
        end
        op_ld(5'd10, 5'd0);
        expc(0, 1, 0); exps(32'h1E, 4'd4, 32'd3); tick();
        wb(5'd1);
        expc(0, 1, 0); exps(32'h1E, 4'd4, 32'd4); tick();
        expc(1, 0, 0); exps(32'h1C, 4'd3, 32'd5); tick();
        idle();
        wb(5'd2);  exps(32'h41C, 4'd4, 32'd5); tick();
        wb(5'd3);  exps(32'h418, 4'd3, 32'd5); tick();
        wb(5'd4);  exps(32'h410, 4'd2, 32'd5); tick();
        wb(5'd10); exps(32'h400, 4'd1, 32'd5); tick();
        exps(32'h0, 4'd0, 32'd5); tick();

        // WAW and x0 handling
        op_ld(5'd7, 5'd0); expc(1, 0, 0); tick();
        op_alu(5'd7, 5'd0, 5'd0);
        expc(0, 1, 0); exps(32'h80, 4'd1, 32'd5); tick();
        op_alu(5'd0, 5'd0, 5'd0);
        expc(1, 0, 0); exps(32'h80, 4'd1, 32'd6); tick();
        op_alu(5'd7, 5'd0, 5'd0); wb(5'd7);
        expc(0, 1, 0); exps(32'h80, 4'd1, 32'd6); tick();
        expc(1, 0, 0); exps(32'h0,  4'd0, 32'd7); tick();
        op_ld(5'd0, 5'd0); expc(1, 0, 0); tick();
        idle(); wb(5'd0);
        exps(32'h0, 4'd1, 32'd7); tick();
        exps(32'h0, 4'd0, 32'd7); tick();

        // redirect window, then an extended one, then EX back-pressure
        op_alu(5'd8, 5'd1, 5'd2);
        ex_redirect = 1'b1; expc(0, 0, 1); tick();
        expc(0, 0, 1); tick();
        expc(0, 0, 1); tick();
        expc(1, 0, 0); exps(32'h0, 4'd0, 32'd7); tick();
        ex_redirect = 1'b1; expc(0, 0, 1); tick();
        ex_redirect = 1'b1; expc(0, 0, 1); tick();
        expc(0, 0, 1); tick();
        expc(0, 0, 1); tick();
        expc(1, 0, 0); exps(32'h0, 4'd0, 32'd7); tick();
        ex_ready = 1'b0; expc(0, 1, 0); tick();
        ex_ready = 1'b1; expc(1, 0, 0); exps(32'h0, 4'd0, 32'd8); tick();

        // simultaneous set and clear of different registers
        op_ld(5'd3, 5'd0); tick();
        op_ld(5'd4, 5'd0); tick();
        op_ld(5'd9, 5'd0); wb(5'd3);
        expc(1, 0, 0); exps(32'h18, 4'd2, 32'd8); tick();
        idle(); wb(5'd4);
        exps(32'h210, 4'd2, 32'd8); tick();
        wb(5'd9); tick();
        exps(32'h0, 4'd0, 32'd8); tick();

        // async reset mid-cycle while in REDIRECT with loads outstanding
        op_ld(5'd1, 5'd0); tick();
        op_ld(5'd2, 5'd0); tick();
        op_ld(5'd3, 5'd0); tick();
        idle(); ex_redirect = 1'b1;
        expc(0, 0, 1); exps(32'hE, 4'd3, 32'd8); tick();
        #1;
        expc(0, 0, 1); compare_all();
        rst_n = 1'b0;
        #1;
        expc(0, 0, 0); exps(32'h0, 4'd0, 32'd0); compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op_alu(5'd6, 5'd1, 5'd2);
        expc(1, 0, 0); exps(32'h0, 4'd0, 32'd0); tick();
        idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
